calc_seq_engine: RTL and testbench
==================================

// Module: calc_seq_engine
// PURPOSE
//  Parametrised successor to the board calculator datapath. Per-digit increment counters build two
//  decimal operands; on op_go a multi-cycle FSM computes add/sub/mul/div, then converts to BCD.
//  Result is held with busy/done handshake and sign/error flags. Sits between button debouncers and
//  the 7-seg scan/decoder.
// PARAMETERS
//  OPD_DIGITS  2  decimal digits per operand; operand max = 10**OPD_DIGITS-1
//  RES_DIGITS  4  BCD result digits; must satisfy 10**RES_DIGITS > (10**OPD_DIGITS-1)**2
//  Derived: OPW = clog2(10**OPD_DIGITS); RW = 2*OPW (binary result width)
// PORTS
//  clk       in   1               system clock (all logic on rising edge)
//  rst       in   1               asynchronous, active-low reset
//  btn_inc   in   2*OPD_DIGITS    1-cycle pulses; bit i increments digit i (upper half = A, lower = B, MSD first)
//  op_sel    in   2               0 add, 1 sub, 2 mul, 3 div; sampled with op_go
//  op_go     in   1               1-cycle start pulse
//  clr       in   1               synchronous clear
//  digits    out  4*OPD_DIGITS*2  current entry digits (BCD), for display in entry mode
//  res_bcd   out  4*RES_DIGITS    result magnitude, BCD, MSD at top
//  res_neg   out  1               result negative (sub only)
//  res_err   out  1               divide-by-zero
//  busy      out  1               high from cycle after op_go until done
//  done      out  1               1-cycle pulse when res_* become valid
// BEHAVIOUR
//  Reset (rst=0, async): all digits 0, res_bcd 0, res_neg 0, res_err 0, busy 0, done 0, FSM IDLE.
//  Digit counters: each btn_inc bit adds 1 mod 10 (9->0 wrap, no carry to next digit).
//   Ignored while busy. Several bits in the same cycle each act independently.
//  FSM: IDLE -> LOAD -> [DIV] -> CONV -> DONE -> IDLE.
//   IDLE: op_go=1 latches A, B (binary via digit*10^k sum) and op_sel; busy<=1; -> LOAD.
//   LOAD (1 cycle): add: A+B; sub: A>=B ? A-B : B-A, neg=(A<B); mul: A*B -> CONV.
//     div: B==0 -> res_err=1, magnitude 0, skip to CONV; else -> DIV.
//   DIV: restoring shift-subtract, exactly OPW cycles, one quotient bit/cycle. Quotient truncated,
//     remainder discarded.
//   CONV: sequential double-dabble, exactly RW cycles, in sub-module.
//   DONE (1 cycle): res_* registers update, done=1, busy<=0 -> IDLE.
//  Latency (op_go sampling edge = edge 0): done high after edge 2+RW (non-div or div-by-zero),
//   2+OPW+RW (div). Defaults (OPW=7, RW=14): 16 / 23 cycles.
//  res_* hold previous values during busy; change only in DONE cycle or on clr/reset.
//  op_go while busy: ignored (no queueing). op_go with btn_inc same cycle: pre-increment digits latched.
//  clr=1: next edge forces IDLE, digits 0, res_* 0, busy 0, done 0; clr beats op_go and btn_inc;
//   clr mid-operation aborts it with no done pulse.
//  Result width: mul uses full RW; add/sub zero-extended to RW. No overflow possible under the
//   RES_DIGITS constraint above; elaboration must fail ($error/assert) if violated.
// STRUCTURE
//  Shared header calc_defs.vh: OP_ADD/OP_SUB/OP_MUL/OP_DIV codes, FSM state encodings,
//   clog2 function, error-digit codes reused by the display decoder.
//  Sub-module bin2bcd_seq #(BIN_W=RW, DIGITS=RES_DIGITS): start/busy/done, iterative
//   double dabble, one shift per cycle. Engine owns counters, operand conversion, FSM, divider.
// TESTING
//  1 Reset with digits nonzero -> all outputs 0 asynchronously; busy=0 before next edge.
//  2 A=12,B=34 (btn pulses), op=add, op_go -> done at edge 16, res_bcd=0x0046, neg=0, err=0.
//  3 A=07,B=45, op=sub -> res_bcd=0x0038, res_neg=1; then A=45,B=07 -> 0x0038, neg=0.
//  4 A=99,B=99, op=mul -> res_bcd=0x9801; A=99,B=07, op=div -> 0x0014 at edge 23.
//  5 B=00, op=div -> done at edge 16, res_err=1, res_bcd=0; digit 9 + btn pulse -> 0, no carry.
//  6 op_go during busy ignored (one done only); clr at edge 5 of div -> no done, busy=0, res=0.

Source files
------------

// File: rtl/calc_seq_engine_pkg.sv
// Shared definitions for the sequential calculator engine: op codes, FSM states,
// display error-digit codes and elaboration-time helper functions.
package calc_seq_engine_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2,
        OP_DIV = 2'd3
    } calc_op_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_DIV  = 3'd2,
        ST_CONV = 3'd3,
        ST_DONE = 3'd4
    } calc_state_e;

    // Codes the 7-seg decoder renders as "E", "r" and blank when res_err is set.
    localparam logic [3:0] DIG_ERR_E = 4'hE;
    localparam logic [3:0] DIG_ERR_R = 4'hA;
    localparam logic [3:0] DIG_BLANK = 4'hF;

    function automatic longint pow10(input int n);
        longint p;
        p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

    function automatic int calc_clog2(input longint v);
        int     r;
        longint x;
        r = 0;
        x = v - 1;
        while (x > 0) begin
            r++;
            x = x >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/calc_seq_engine_bin2bcd.sv
// Iterative double-dabble binary-to-BCD converter, one shift per clock.
// The start edge loads and performs the first shift, so a conversion takes BIN_W edges.
module bin2bcd_seq
    import calc_seq_engine_pkg::*;
#(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  busy,
    output logic                  done
);
    localparam int CW = calc_clog2(BIN_W);

    logic [BIN_W-1:0]    sh_q;
    logic [CW-1:0]       cnt_q;
    logic [4*DIGITS-1:0] adj;

    always_comb begin
        adj = bcd;
        for (int d = 0; d < DIGITS; d++) begin
            if (bcd[4*d +: 4] >= 4'd5) adj[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bcd   <= '0;
            sh_q  <= '0;
            cnt_q <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (clr) begin
                bcd   <= '0;
                sh_q  <= '0;
                cnt_q <= '0;
                busy  <= 1'b0;
            end else if (start) begin
                // Adjusting an all-zero BCD field is a no-op, so the first shift happens on load.
                bcd   <= {{(4*DIGITS-1){1'b0}}, bin[BIN_W-1]};
                sh_q  <= bin << 1;
                cnt_q <= CW'(BIN_W - 1);
                busy  <= 1'b1;
            end else if (busy) begin
                bcd   <= {adj[4*DIGITS-2:0], sh_q[BIN_W-1]};
                sh_q  <= sh_q << 1;
                cnt_q <= cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/calc_seq_engine.sv
// Calculator engine: per-digit entry counters, operand conversion, op FSM with
// restoring divider, and a sequential BCD converter for the result.
module calc_seq_engine
    import calc_seq_engine_pkg::*;
#(
    parameter int OPD_DIGITS = 2,
    parameter int RES_DIGITS = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [2*OPD_DIGITS-1:0]   btn_inc,
    input  logic [1:0]                op_sel,
    input  logic                      op_go,
    input  logic                      clr,
    output logic [4*OPD_DIGITS*2-1:0] digits,
    output logic [4*RES_DIGITS-1:0]   res_bcd,
    output logic                      res_neg,
    output logic                      res_err,
    output logic                      busy,
    output logic                      done,
    output logic [3:0]                state_dbg
);
    localparam int     ND      = 2 * OPD_DIGITS;
    localparam int     OPW     = calc_clog2(pow10(OPD_DIGITS));
    localparam int     RW      = 2 * OPW;
    localparam int     DCW     = calc_clog2(OPW + 1);
    localparam longint OPD_MAX = pow10(OPD_DIGITS) - 1;

    if (pow10(RES_DIGITS) <= OPD_MAX * OPD_MAX) begin : g_cfg_check
        $error("calc_seq_engine: RES_DIGITS too small for OPD_DIGITS product");
    end

    calc_state_e         state;
    calc_op_e            op_q;
    logic [3:0]          dig_q [ND];
    logic [OPW-1:0]      opd_a, opd_b, a_q, b_q, rem_q, quo_q;
    logic [RW-1:0]       mag_q;
    logic [DCW-1:0]      div_cnt;
    logic                neg_q, err_q, conv_start;
    logic [4*RES_DIGITS-1:0] conv_bcd;
    logic                conv_busy, conv_done;
    logic [OPW:0]        trial, rem_nx;
    logic                trial_ge;
    logic [OPW-1:0]      quo_nx;

    always_comb begin
        digits = '0;
        opd_a  = '0;
        opd_b  = '0;
        for (int i = 0; i < ND; i++) digits[4*i +: 4] = dig_q[i];
        for (int k = 0; k < OPD_DIGITS; k++) begin
            opd_a = opd_a + OPW'(dig_q[OPD_DIGITS+k]) * OPW'(pow10(k));
            opd_b = opd_b + OPW'(dig_q[k]) * OPW'(pow10(k));
        end
    end

    // One restoring-division step: shift the next dividend bit into the remainder.
    assign trial    = {rem_q, quo_q[OPW-1]};
    assign trial_ge = trial >= {1'b0, b_q};
    assign rem_nx   = trial_ge ? trial - {1'b0, b_q} : trial;
    assign quo_nx   = {quo_q[OPW-2:0], trial_ge};

    assign state_dbg = {conv_busy, state};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ND; i++) dig_q[i] <= '0;
        end else if (clr) begin
            for (int i = 0; i < ND; i++) dig_q[i] <= '0;
        end else if (!busy) begin
            for (int i = 0; i < ND; i++) begin
                if (btn_inc[i]) dig_q[i] <= (dig_q[i] == 4'd9) ? 4'd0 : dig_q[i] + 4'd1;
            end
        end
    end

    // Handshake: busy rises the cycle after an accepted op_go and falls together with a
    // one-cycle done pulse; res_* are valid from that done cycle until the next done or clr.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            op_q       <= OP_ADD;
            a_q        <= '0;
            b_q        <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            mag_q      <= '0;
            div_cnt    <= '0;
            neg_q      <= 1'b0;
            err_q      <= 1'b0;
            conv_start <= 1'b0;
            res_bcd    <= '0;
            res_neg    <= 1'b0;
            res_err    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else if (clr) begin
            state      <= ST_IDLE;
            conv_start <= 1'b0;
            res_bcd    <= '0;
            res_neg    <= 1'b0;
            res_err    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done       <= 1'b0;
            conv_start <= 1'b0;
            case (state)
                ST_IDLE: if (op_go) begin
                    a_q   <= opd_a;
                    b_q   <= opd_b;
                    op_q  <= calc_op_e'(op_sel);
                    neg_q <= 1'b0;
                    err_q <= 1'b0;
                    busy  <= 1'b1;
                    state <= ST_LOAD;
                end
                ST_LOAD: begin
                    state      <= ST_CONV;
                    conv_start <= 1'b1;
                    case (op_q)
                        OP_ADD: mag_q <= RW'(a_q) + RW'(b_q);
                        OP_SUB: begin
                            mag_q <= (a_q >= b_q) ? RW'(a_q - b_q) : RW'(b_q - a_q);
                            neg_q <= a_q < b_q;
                        end
                        OP_MUL: mag_q <= RW'(a_q) * RW'(b_q);
                        default: begin
                            if (b_q == '0) begin
                                err_q <= 1'b1;
                                mag_q <= '0;
                            end else begin
                                rem_q      <= '0;
                                quo_q      <= a_q;
                                div_cnt    <= DCW'(OPW);
                                conv_start <= 1'b0;
                                state      <= ST_DIV;
                            end
                        end
                    endcase
                end
                ST_DIV: begin
                    rem_q   <= rem_nx[OPW-1:0];
                    quo_q   <= quo_nx;
                    div_cnt <= div_cnt - 1'b1;
                    if (div_cnt == DCW'(1)) begin
                        mag_q      <= RW'(quo_nx);
                        conv_start <= 1'b1;
                        state      <= ST_CONV;
                    end
                end
                ST_CONV: if (conv_done) begin
                    res_bcd <= conv_bcd;
                    res_neg <= neg_q;
                    res_err <= err_q;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state   <= ST_DONE;
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    bin2bcd_seq #(.BIN_W(RW), .DIGITS(RES_DIGITS)) u_bin2bcd (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .start (conv_start),
        .bin   (mag_q),
        .bcd   (conv_bcd),
        .busy  (conv_busy),
        .done  (conv_done)
    );

endmodule

// File: tb/tb_calc_seq_engine.sv
// Directed bench for calc_seq_engine: drivers push expected results and done cycles,
// a negedge monitor pops and compares on every done pulse.
module tb_calc_seq_engine;
  localparam int ND = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  btn_inc = '0;
  logic [1:0]  op_sel = '0;
  logic        op_go = 1'b0;
  logic        clr = 1'b0;
  logic [15:0] digits, res_bcd;
  logic        res_neg, res_err, busy, done;
  logic [3:0]  state_dbg;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int cur [ND];
  logic [17:0] exp_q[$];
  int          exp_cyc_q[$];
  logic [17:0] mon_e;
  int          mon_c;

  calc_seq_engine #(.OPD_DIGITS(2), .RES_DIGITS(4)) dut (
    .clk(clk), .rst(rst), .btn_inc(btn_inc), .op_sel(op_sel), .op_go(op_go), .clr(clr),
    .digits(digits), .res_bcd(res_bcd), .res_neg(res_neg), .res_err(res_err),
    .busy(busy), .done(done), .state_dbg(state_dbg)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst && done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected none (cycle %0d)", cyc);
      end else begin
        mon_e = exp_q.pop_front();
        mon_c = exp_cyc_q.pop_front();
        check("result", {14'd0, res_neg, res_err, res_bcd}, {14'd0, mon_e});
        check("latency", mon_c, cyc);
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input int b);
    btn_inc[b] = 1'b1;
    tick();
    btn_inc = '0;
  endtask

  task automatic enter(input int a, input int b);
    int tgt [ND];
    logic [15:0] ed;
    tgt[3] = a / 10; tgt[2] = a % 10; tgt[1] = b / 10; tgt[0] = b % 10;
    ed = '0;
    for (int i = 0; i < ND; i++) begin
      while (cur[i] != tgt[i]) begin
        press(i);
        cur[i] = (cur[i] + 1) % 10;
      end
      ed[4*i +: 4] = 4'(tgt[i]);
    end
    check("digits_entry", {16'd0, digits}, {16'd0, ed});
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done expected one within 100 cycles");
      exp_q.delete();
      exp_cyc_q.delete();
    end
    tick();
  endtask

  task automatic do_op(input logic [1:0] op, input logic [15:0] eb, input logic neg,
                       input logic err, input int lat, input logic [3:0] btn);
    op_sel = op;
    op_go = 1'b1;
    btn_inc = btn;
    exp_q.push_back({neg, err, eb});
    exp_cyc_q.push_back(cyc + 1 + lat);
    tick();
    op_go = 1'b0;
    btn_inc = '0;
    check("busy_high", {31'd0, busy}, 32'd1);
    wait_drain();
  endtask

  initial begin
    for (int i = 0; i < ND; i++) cur[i] = 0;
    repeat (3) tick();
    check("reset_digits", {16'd0, digits}, 32'd0);
    check("reset_res", {14'd0, res_neg, res_err, res_bcd}, 32'd0);
    check("reset_busy_done", {30'd0, busy, done}, 32'd0);
    rst = 1'b1;
    tick();

    // add, then op_go with a same-cycle increment latches pre-increment digits
    enter(12, 34);
    do_op(2'd0, 16'h0046, 1'b0, 1'b0, 16, 4'b0000);
    do_op(2'd0, 16'h0046, 1'b0, 1'b0, 16, 4'b0001);
    cur[0] = 5;
    check("digits_preinc", {16'd0, digits}, 32'h1235);

    // subtract both orders
    enter(7, 45);
    do_op(2'd1, 16'h0038, 1'b1, 1'b0, 16, 4'b0000);
    enter(45, 7);
    do_op(2'd1, 16'h0038, 1'b0, 1'b0, 16, 4'b0000);

    // multiply max, divide
    enter(99, 99);
    do_op(2'd2, 16'h9801, 1'b0, 1'b0, 16, 4'b0000);
    enter(99, 7);
    do_op(2'd3, 16'h0014, 1'b0, 1'b0, 23, 4'b0000);

    // divide by zero; digit wrap without carry; simultaneous increments
    enter(59, 0);
    do_op(2'd3, 16'h0000, 1'b0, 1'b1, 16, 4'b0000);
    press(2);
    cur[2] = 0;
    check("digit_wrap", {16'd0, digits}, 32'h5000);
    btn_inc = 4'hF;
    tick();
    btn_inc = '0;
    for (int i = 0; i < ND; i++) cur[i] = (cur[i] + 1) % 10;
    check("digit_multi", {16'd0, digits}, 32'h6111);

    // op_go and btn_inc while busy are ignored: exactly one done
    enter(12, 34);
    op_sel = 2'd0;
    op_go = 1'b1;
    exp_q.push_back({1'b0, 1'b0, 16'h0046});
    exp_cyc_q.push_back(cyc + 17);
    tick();
    op_go = 1'b0;
    repeat (4) tick();
    op_sel = 2'd2;
    op_go = 1'b1;
    btn_inc = 4'b0001;
    tick();
    op_go = 1'b0;
    btn_inc = '0;
    check("digits_busy", {16'd0, digits}, 32'h1234);
    wait_drain();
    repeat (30) tick();

    // clr sampled at edge 5 of a divide aborts it
    enter(99, 7);
    op_sel = 2'd3;
    op_go = 1'b1;
    tick();
    op_go = 1'b0;
    check("res_hold", {16'd0, res_bcd}, 32'h0046);
    repeat (4) tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int i = 0; i < ND; i++) cur[i] = 0;
    check("clr_busy_done", {30'd0, busy, done}, 32'd0);
    check("clr_res", {14'd0, res_neg, res_err, res_bcd}, 32'd0);
    check("clr_digits", {16'd0, digits}, 32'd0);
    repeat (40) tick();

    // async reset mid-operation with nonzero digits and result
    enter(34, 12);
    do_op(2'd2, 16'h0408, 1'b0, 1'b0, 16, 4'b0000);
    op_sel = 2'd0;
    op_go = 1'b1;
    tick();
    op_go = 1'b0;
    repeat (3) tick();
    #3;
    rst = 1'b0;
    #1;
    check("arst_busy_done", {30'd0, busy, done}, 32'd0);
    check("arst_res", {14'd0, res_neg, res_err, res_bcd}, 32'd0);
    check("arst_digits", {16'd0, digits}, 32'd0);
    tick();
    rst = 1'b1;
    repeat (30) tick();

    check("queue_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
